// File: rtl/conv_pe_array.sv
// conv_pe_array: multi-channel convolution PE.
//   Holds a CH x K weight bank. Each accepted beat carries one tap per channel.
//   After K beats the per-channel accumulators are summed across channels,
//   shifted, quantised to DW bits and packed PACK results per output word.
// Ports:
//   clk, rst                 clock, async active-high reset
//   cfg_we/cfg_ch/cfg_tap/
//   cfg_data                 weight write (IDLE only)
//   start/num_windows/sat_en frame launch (IDLE only), frame parameters
//   act_valid/act_ready/
//   act_data                 activation stream, channel c at [c*DW +: DW]
//   out_valid/out_ready/
//   out_data/out_last        packed result stream, result i at [i*DW +: DW]
//   busy, done               status, done pulses one cycle at frame end

// One channel: weight row plus multiply-accumulate.
module conv_pe_lane #(
   parameter int K  = 16,
   parameter int DW = 8,
   parameter int TW = 4,
   parameter int AW = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [TW-1:0] wr_tap,
   input  logic [DW-1:0] wr_data,
   input  logic [DW-1:0] act,
   input  logic [TW-1:0] tap,
   input  logic          acc_en,
   input  logic          acc_clr,
   output logic [AW-1:0] acc
);
   logic [K-1:0][DW-1:0] w_q;
   logic [AW-1:0]        acc_q;
   logic [2*DW-1:0]      prod;

   assign prod = {{DW{1'b0}}, act} * {{DW{1'b0}}, w_q[tap]};
   assign acc  = acc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q   <= '0;
         acc_q <= '0;
      end else begin
         if (wr_en) w_q[wr_tap] <= wr_data;
         if (acc_clr)     acc_q <= '0;
         else if (acc_en) acc_q <= acc_q + AW'(prod);
      end
   end
endmodule

module conv_pe_array #(
   parameter int CH        = 4,
   parameter int K         = 16,
   parameter int DW        = 8,
   parameter int OUT_SHIFT = 4,
   parameter int PACK      = 4,
   localparam int CW = (CH > 1) ? $clog2(CH) : 1,
   localparam int TW = $clog2(K)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [CW-1:0]      cfg_ch,
   input  logic [TW-1:0]      cfg_tap,
   input  logic [DW-1:0]      cfg_data,
   input  logic               start,
   input  logic [15:0]        num_windows,
   input  logic               sat_en,
   input  logic               act_valid,
   output logic               act_ready,
   input  logic [CH*DW-1:0]   act_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PACK*DW-1:0] out_data,
   output logic               out_last,
   output logic               busy,
   output logic               done
);
   localparam int AW = 2*DW + $clog2(K);
   localparam int SW = AW + $clog2(CH);
   localparam int PW = $clog2(PACK + 1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_RED, S_OUT, S_DONE} state_t;

   state_t                 state_q;
   logic [TW-1:0]          tap_q;
   logic [PW-1:0]          pack_cnt_q;
   logic [15:0]            win_cnt_q, num_win_q;
   logic                   sat_q, last_q;
   logic [PACK-1:0][DW-1:0] pack_q;

   logic [CH-1:0][AW-1:0]  acc;
   logic [SW-1:0]          sum_d, shifted_d;
   logic [DW-1:0]          res_d;
   logic [15:0]            win_next;
   logic                   last_win, pack_full;

   generate
      for (genvar g = 0; g < CH; g++) begin : g_lane
         conv_pe_lane #(.K(K), .DW(DW), .TW(TW), .AW(AW)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (cfg_we && (state_q == S_IDLE) && (cfg_ch == CW'(g))),
            .wr_tap  (cfg_tap),
            .wr_data (cfg_data),
            .act     (act_data[g*DW +: DW]),
            .tap     (tap_q),
            .acc_en  ((state_q == S_RUN) && act_valid),
            .acc_clr (state_q == S_RED),
            .acc     (acc[g])
         );
      end
   endgenerate

   // Cross-channel reduction and quantisation, consumed only in S_RED.
   always_comb begin
      sum_d = '0;
      for (int c = 0; c < CH; c++) sum_d = sum_d + SW'(acc[c]);
      shifted_d = sum_d >> OUT_SHIFT;
      if (sat_q && (shifted_d > SW'({DW{1'b1}}))) res_d = '1;
      else                                         res_d = shifted_d[DW-1:0];
   end

   assign win_next  = win_cnt_q + 16'd1;
   assign last_win  = (win_next == num_win_q);
   assign pack_full = (pack_cnt_q == PW'(PACK - 1));

   assign act_ready = (state_q == S_RUN);
   assign out_valid = (state_q == S_OUT);
   assign out_last  = (state_q == S_OUT) && last_q;
   // Only expose the pack register while offering a word.
   assign out_data  = (state_q == S_OUT) ? pack_q : '0;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tap_q      <= '0;
         pack_cnt_q <= '0;
         win_cnt_q  <= '0;
         num_win_q  <= '0;
         sat_q      <= 1'b0;
         last_q     <= 1'b0;
         pack_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               num_win_q  <= num_windows;
               sat_q      <= sat_en;
               win_cnt_q  <= '0;
               pack_cnt_q <= '0;
               pack_q     <= '0;
               tap_q      <= '0;
               last_q     <= 1'b0;
               state_q    <= (num_windows == 16'd0) ? S_DONE : S_RUN;
            end
            S_RUN: if (act_valid) begin
               if (tap_q == TW'(K - 1)) begin
                  tap_q   <= '0;
                  state_q <= S_RED;
               end else begin
                  tap_q <= tap_q + 1'b1;
               end
            end
            S_RED: begin
               for (int i = 0; i < PACK; i++)
                  if (pack_cnt_q == PW'(i)) pack_q[i] <= res_d;
               pack_cnt_q <= pack_cnt_q + 1'b1;
               win_cnt_q  <= win_next;
               last_q     <= last_win;
               state_q    <= (pack_full || last_win) ? S_OUT : S_RUN;
            end
            S_OUT: if (out_ready) begin
               pack_q     <= '0;
               pack_cnt_q <= '0;
               state_q    <= last_q ? S_DONE : S_RUN;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_pe_array.sv
module tb_conv_pe_array;
   localparam int CH = 4, K = 16, DW = 8, OUT_SHIFT = 4, PACK = 4;
   localparam int WW = PACK*DW;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [1:0]        cfg_ch;
   logic [3:0]        cfg_tap;
   logic [DW-1:0]     cfg_data;
   logic              start;
   logic [15:0]       num_windows;
   logic              sat_en;
   logic              act_valid;
   logic              act_ready;
   logic [CH*DW-1:0]  act_data;
   logic              out_valid;
   logic              out_ready;
   logic [WW-1:0]     out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   conv_pe_array #(.CH(CH), .K(K), .DW(DW), .OUT_SHIFT(OUT_SHIFT), .PACK(PACK)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tap(cfg_tap),
      .cfg_data(cfg_data), .start(start), .num_windows(num_windows), .sat_en(sat_en),
      .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int wm [CH][K];
   logic [CH*DW-1:0] beats[$];
   logic [WW-1:0] got_w[$], exp_w[$];
   bit got_l[$], exp_l[$];

   typedef struct {
      int w; int a; int nwin; bit sat; int nexp;
      logic [WW-1:0] e0; bit l0; logic [WW-1:0] e1; bit l1;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
      end
   endtask

   task automatic load_w();
      for (int c = 0; c < CH; c++)
         for (int t = 0; t < K; t++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_ch = 2'(c); cfg_tap = 4'(t); cfg_data = 8'(wm[c][t]);
         end
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic set_w_const(input int v);
      for (int c = 0; c < CH; c++)
         for (int t = 0; t < K; t++) wm[c][t] = v;
   endtask

   task automatic fill_const(input int nwin, input int a);
      beats.delete();
      for (int i = 0; i < nwin*K; i++) beats.push_back({CH{8'(a)}});
   endtask

   task automatic fill_ramp(input int nwin);
      int base;
      logic [CH*DW-1:0] b;
      base = $urandom_range(255);
      beats.delete();
      for (int i = 0; i < nwin*K; i++) begin
         for (int c = 0; c < CH; c++) b[c*DW +: DW] = 8'(base + i*3 + c*17);
         beats.push_back(b);
      end
   endtask

   // Golden model: plain dot products per window, shift, clamp or wrap, pack.
   task automatic model(input int nwin, input bit sat);
      longint s;
      logic [WW-1:0] w;
      logic [CH*DW-1:0] b;
      int slot;
      exp_w.delete(); exp_l.delete(); w = '0;
      for (int n = 0; n < nwin; n++) begin
         s = 0;
         for (int t = 0; t < K; t++) begin
            b = beats[n*K + t];
            for (int c = 0; c < CH; c++) s += longint'(b[c*DW +: DW]) * wm[c][t];
         end
         s = s / (longint'(1) << OUT_SHIFT);
         if (sat) s = (s > 255) ? 255 : s;
         else     s = s % 256;
         slot = n % PACK;
         w[slot*DW +: DW] = 8'(s);
         if (slot == PACK-1 || n == nwin-1) begin
            exp_w.push_back(w); exp_l.push_back(n == nwin-1); w = '0;
         end
      end
   endtask

   task automatic run_frame(input int nwin, input bit sat, input int gap_pct,
                            input int rdy_pct, input bit poke, input int stall_n);
      int bi, cyc, hs, dn, stall_left, bi_hold;
      bit resume, stall_chk;
      logic [WW-1:0] held;
      bi = 0; cyc = 0; hs = -1; dn = -1; stall_left = stall_n; bi_hold = 0;
      resume = 0; stall_chk = 0; held = '0;
      got_w.delete(); got_l.delete();
      @(negedge clk);
      start = 1'b1; num_windows = 16'(nwin); sat_en = sat;
      @(negedge clk);
      start = 1'b0;
      if (nwin > 0) begin
         check("start busy", busy, 1);
         check("start act_ready", act_ready, 1);
      end else begin
         check("empty done", done, 1);
      end
      while (cyc < 20000) begin
         if (done) begin dn = cyc; break; end
         if (resume) begin check("resume act_ready", act_ready, 1); resume = 0; end
         if (stall_n > 0 && stall_left == 0 && !stall_chk) begin
            check("stall beats held", bi, bi_hold); stall_chk = 1;
         end
         if (stall_left > 0 && (out_valid || stall_left < stall_n)) begin
            if (stall_left == stall_n) begin held = out_data; bi_hold = bi; end
            else begin
               check("stall out_valid", out_valid, 1);
               check("stall out_data", out_data, held);
            end
            check("stall act_ready", act_ready, 0);
            out_ready = 1'b0; stall_left--;
         end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
         end
         if (out_valid && out_ready) begin
            got_w.push_back(out_data); got_l.push_back(out_last); hs = cyc;
            if (!out_last) resume = 1;
         end
         if (bi < nwin*K && $urandom_range(99) >= gap_pct) begin
            act_valid = 1'b1; act_data = beats[bi];
         end else begin
            act_valid = 1'b0; act_data = $urandom;
         end
         if (act_valid && act_ready) bi++;
         if (poke) begin
            cfg_we = 1'b1; cfg_ch = 2'($urandom_range(CH-1));
            cfg_tap = 4'($urandom_range(K-1)); cfg_data = 8'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      act_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
      check("frame done seen", (dn >= 0), 1);
      if (dn >= 0 && nwin > 0) check("done after last handshake", dn - hs, 1);
      if (nwin > 0) check("beats consumed", bi, nwin*K);
      @(negedge clk);
      check("idle busy", busy, 0);
      check("done one cycle", done, 0);
   endtask

   task automatic cmp_frame(input string tag);
      check({tag, " words"}, got_w.size(), exp_w.size());
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
         check($sformatf("%s w%0d data", tag, i), got_w[i], exp_w[i]);
         check($sformatf("%s w%0d last", tag, i), got_l[i], exp_l[i]);
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_tap = 0; cfg_data = 0; start = 0;
      num_windows = 0; sat_en = 0; act_valid = 0; act_data = 0; out_ready = 0;

      tbl[0] = '{1,   1,   4, 1'b1, 1, 32'h04040404, 1'b1, 32'h0,        1'b0};
      tbl[1] = '{255, 255, 1, 1'b1, 1, 32'h000000FF, 1'b1, 32'h0,        1'b0};
      tbl[2] = '{255, 255, 1, 1'b0, 1, 32'h00000004, 1'b1, 32'h0,        1'b0};
      tbl[3] = '{1,   1,   6, 1'b1, 2, 32'h04040404, 1'b0, 32'h00000404, 1'b1};
      tbl[4] = '{1,   1,   0, 1'b1, 0, 32'h0,        1'b0, 32'h0,        1'b0};

      repeat (2) @(negedge clk);
      check("rst act_ready", act_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst out_last",  out_last,  0);
      check("rst busy",      busy,      0);
      check("rst done",      done,      0);
      check("rst out_data",  out_data,  0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         set_w_const(tbl[v].w);
         load_w();
         fill_const(tbl[v].nwin, tbl[v].a);
         run_frame(tbl[v].nwin, tbl[v].sat, 0, 100, 0, 0);
         check($sformatf("tbl%0d words", v), got_w.size(), tbl[v].nexp);
         if (tbl[v].nexp > 0 && got_w.size() > 0) begin
            check($sformatf("tbl%0d w0", v), got_w[0], tbl[v].e0);
            check($sformatf("tbl%0d l0", v), got_l[0], tbl[v].l0);
         end
         if (tbl[v].nexp > 1 && got_w.size() > 1) begin
            check($sformatf("tbl%0d w1", v), got_w[1], tbl[v].e1);
            check($sformatf("tbl%0d l1", v), got_l[1], tbl[v].l1);
         end
      end

      // Backpressure on a non-final word, then resume.
      set_w_const(1); load_w();
      fill_const(8, 1);
      run_frame(8, 1'b1, 0, 100, 0, 5);
      model(8, 1'b1);
      cmp_frame("stall");

      // Random weights, ramp activations, ~50% bubbles, random out_ready.
      for (int r = 0; r < 3; r++) begin
         int nw; bit st;
         for (int c = 0; c < CH; c++)
            for (int t = 0; t < K; t++) wm[c][t] = $urandom_range(255);
         load_w();
         nw = $urandom_range(9, 1);
         st = 1'($urandom_range(1));
         fill_ramp(nw);
         run_frame(nw, st, 50, 70, 0, 0);
         model(nw, st);
         cmp_frame($sformatf("rand%0d", r));
      end

      // Weight writes while running must be ignored, now and in the next frame.
      fill_ramp(3);
      run_frame(3, 1'b0, 30, 80, 1, 0);
      model(3, 1'b0);
      cmp_frame("poke");
      fill_ramp(5);
      run_frame(5, 1'b0, 30, 80, 0, 0);
      model(5, 1'b0);
      cmp_frame("post-poke");

      // Reset in the middle of a window.
      fill_const(4, 1);
      @(negedge clk);
      start = 1'b1; num_windows = 16'd4; sat_en = 1'b1;
      @(negedge clk);
      start = 1'b0; act_valid = 1'b1; act_data = beats[0];
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst act_ready", act_ready, 0);
      check("midrst busy",      busy,      0);
      check("midrst out_valid", out_valid, 0);
      check("midrst done",      done,      0);
      check("midrst out_data",  out_data,  0);
      act_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      set_w_const(2); load_w();
      fill_const(4, 1);
      run_frame(4, 1'b1, 0, 100, 0, 0);
      model(4, 1'b1);
      cmp_frame("after-rst");
      if (got_w.size() > 0) check("after-rst word", got_w[0], 32'h08080808);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
